// File: rtl/lapido_pkg.sv
// Shared definitions for the Lapido front end.
//   fetch_state_t : fetch sequencer states (REQ / HOLD / DROP)
//   INSTR_WIDTH   : instruction word width
//   PC_STEP       : byte distance between consecutive instruction words
//   OPC_*         : opcode field location and values, shared with the control unit
package lapido_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Opcode field is instr[31:29].
    localparam int          OPC_HI  = 31;
    localparam int          OPC_LO  = 29;
    localparam logic [2:0]  OPC_ALU = 3'b001;
    localparam logic [2:0]  OPC_MEM = 3'b100;

    function automatic logic [2:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {instruction, pc} pairs between fetch and decode.
// Implemented as a shift register so the head entry sits in fixed flops and
// drives the stage outputs directly.
//   clock, reset            : clock, synchronous active-high reset
//   push, push_instr/pc     : enqueue one entry (ignored when full and not popping)
//   pop                     : dequeue the head (ignored when empty)
//   flush                   : empty the buffer; wins over push and pop
//   head_instr/pc/valid     : registered head entry and non-empty flag
//   count                   : number of valid entries
module fetch_buffer
    import lapido_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 32,
    localparam int CW        = $clog2(DEPTH) + 1
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [INSTR_WIDTH-1:0] push_instr,
    input  logic [ADDR_WIDTH-1:0]  push_pc,
    output logic [INSTR_WIDTH-1:0] head_instr,
    output logic [ADDR_WIDTH-1:0]  head_pc,
    output logic                   head_valid,
    output logic [CW-1:0]          count
);

    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_d [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_d    [DEPTH];
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic [CW-1:0]          wr_idx;
    logic                   valid_q;
    logic                   pop_ok;
    logic                   push_ok;

    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);
    // When popping in the same cycle the tail slot moves down by one.
    assign wr_idx  = pop_ok ? (count_q - CW'(1)) : count_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            instr_d[i] = instr_q[i];
            pc_d[i]    = pc_q[i];
        end
        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                instr_d[i] = instr_q[i+1];
                pc_d[i]    = pc_q[i+1];
            end
        end
        if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CW'(i)) begin
                    instr_d[i] = push_instr;
                    pc_d[i]    = push_pc;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            count_q <= count_d;
            valid_q <= (count_d != '0);
            // A flush only clears occupancy; stale data is hidden by head_valid.
            if (!flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    instr_q[i] <= instr_d[i];
                    pc_q[i]    <= pc_d[i];
                end
            end
        end
    end

    assign head_instr = instr_q[0];
    assign head_pc    = pc_q[0];
    assign head_valid = valid_q;
    assign count      = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Lapido fetch stage: owns the PC, fetches words over a req/ack handshake,
// buffers them and hands {instruction, pc} to decode with valid/stall.
// A taken branch flushes the buffer and discards any in-flight fetch.
//   clock, reset                  : clock, synchronous active-high reset
//   imem_req, imem_addr           : fetch request (held with stable address until ack)
//   imem_ack, imem_rdata          : request accepted, data valid the same cycle
//   branch_taken, branch_target   : single-cycle redirect from execute
//   stall                         : decode not ready, hold the head entry
//   instruction, instr_pc         : head entry presented to decode
//   instr_valid                   : head entry valid
module instruction_fetch
    import lapido_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
)(
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  req_q;
    logic                  acked;
    logic                  pop;
    logic                  push;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_after;

    // An ack is only meaningful while our request is actually raised.
    assign acked = imem_ack && req_q;
    // A branch flushes the buffer, so nothing is consumed in that cycle.
    assign pop   = instr_valid && !stall && !branch_taken;
    assign push  = (state_q == REQ) && acked && !branch_taken;
    // REQ is only occupied with count < BUF_DEPTH, so this cannot overflow.
    assign count_after = count + CW'(1) - CW'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        if (branch_taken) begin
            fetch_pc_d = branch_target;
            case (state_q)
                REQ, DROP: begin
                    // With the ack in hand the bus is free: go straight to the target.
                    // Otherwise keep the stale request up until it completes.
                    if (acked) begin
                        state_d = REQ;
                        addr_d  = branch_target;
                    end else begin
                        state_d = DROP;
                    end
                end
                HOLD: begin
                    state_d = REQ;
                    addr_d  = branch_target;
                end
                default: begin
                    state_d = REQ;
                    addr_d  = branch_target;
                end
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (acked) begin
                        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
                        addr_d     = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
                        state_d    = (count_after < CW'(BUF_DEPTH)) ? REQ : HOLD;
                    end
                end
                HOLD: begin
                    if (pop) begin
                        state_d = REQ;
                        addr_d  = fetch_pc_q;
                    end
                end
                DROP: begin
                    if (acked) begin
                        state_d = REQ;
                        addr_d  = fetch_pc_q;
                    end
                end
                default: begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= (state_d != HOLD);
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    fetch_buffer #(
        .DEPTH      (BUF_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buffer (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (branch_taken),
        .push_instr (imem_rdata),
        .push_pc    (addr_q),
        .head_instr (instruction),
        .head_pc    (instr_pc),
        .head_valid (instr_valid),
        .count      (count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;

    // Second instance exercising the address wrap from a high reset PC.
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_instruction;
    logic [31:0] w_pc;
    logic        w_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    int mem_lat  = 0;
    int lat_cnt  = 0;
    logic [31:0] exp_pc = 32'h0;
    logic        last_ack;

    instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .stall(stall),
        .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_wrap (
        .clock(clock), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .branch_taken(1'b0), .branch_target(32'h0),
        .stall(1'b0),
        .instruction(w_instruction), .instr_pc(w_pc), .instr_valid(w_valid)
    );

    // Memory contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {3'b001, a[28:0]} ^ {a[15:0], 16'h5A3C};
    endfunction

    // Zero-latency memory for the wrap instance.
    assign w_ack   = w_req;
    assign w_rdata = word_of(w_addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // One clock cycle: memory responds, reference model consumes pops,
    // then the edge happens and the request protocol is checked.
    task automatic step();
        logic        pre_req;
        logic [31:0] pre_addr;
        if (imem_req === 1'b1 && !reset) begin
            if (lat_cnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = word_of(imem_addr);
                lat_cnt    = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                lat_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            lat_cnt    = 0;
        end
        pre_req  = imem_req;
        pre_addr = imem_addr;
        last_ack = imem_ack;
        // Reference: decode sees an in-order stream starting at the last redirect.
        if (!reset && !branch_taken && instr_valid === 1'b1 && !stall) begin
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_instr", instruction, word_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (reset) exp_pc = 32'h0;
        else if (branch_taken) exp_pc = branch_target;
        @(posedge clock);
        @(negedge clock);
        if (!reset && pre_req === 1'b1 && !last_ack) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, pre_addr);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        stl;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[15];
    bit   found;

    initial begin
        reset = 1'b1; stall = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;

        // Zero-latency memory: reset, stall backpressure, release, streaming, mid-stream reset.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h04};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h10};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h04};

        mem_lat = 0;
        for (int i = 0; i < 15; i++) begin
            reset = tbl[i].rst;
            stall = tbl[i].stl;
            step();
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_instr", i), instruction,
                tbl[i].e_valid ? word_of(tbl[i].e_pc) : 32'h0);
        end

        // Branch while the fetch of 0x8 is outstanding (latency 3).
        mem_lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_req && imem_addr == 32'h8 && lat_cnt == 0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("s1_reach_0x8", 32'(found), 32'd1);
        branch_taken = 1'b1; branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("s1_valid_flushed", 32'(instr_valid), 32'd0);
        chk("s1_stale_addr", imem_addr, 32'h8);
        chk("s1_stale_req", 32'(imem_req), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_ack) begin
                found = 1'b1;
                break;
            end
            chk("s1_drop_addr", imem_addr, 32'h8);
        end
        chk("s1_stale_ack", 32'(found), 32'd1);
        chk("s1_redirect_addr", imem_addr, 32'h100);
        chk("s1_redirect_req", 32'(imem_req), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("s1_valid_again", 32'(found), 32'd1);
        chk("s1_first_pc", instr_pc, 32'h100);

        // Branch in the same cycle as the ack of 0xC: no DROP cycle.
        mem_lat = 0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 32'hC) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("s2_reach_0xC", 32'(found), 32'd1);
        branch_taken = 1'b1; branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        chk("s2_ack_taken", 32'(last_ack), 32'd1);
        chk("s2_addr", imem_addr, 32'h40);
        chk("s2_req", 32'(imem_req), 32'd1);
        chk("s2_valid", 32'(instr_valid), 32'd0);
        step();
        chk("s2_next_addr", imem_addr, 32'h44);
        chk("s2_head_valid", 32'(instr_valid), 32'd1);
        chk("s2_head_pc", instr_pc, 32'h40);

        // Address wrap on the high-reset-PC instance.
        do_reset();
        step();
        chk("wrap_req", 32'(w_req), 32'd1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_valid", 32'(w_valid), 32'd1);
        chk("wrap_pc0", w_pc, 32'hFFFF_FFFC);
        chk("wrap_instr0", w_instruction, word_of(32'hFFFF_FFFC));
        chk("wrap_addr1", w_addr, 32'h0);
        step();
        chk("wrap_pc1", w_pc, 32'h0);
        chk("wrap_addr2", w_addr, 32'h4);

        // Randomised traffic against the stream model.
        do_reset();
        n_pops = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) mem_lat = $urandom_range(0, 3);
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 19) == 0);
            branch_target = $urandom;
            reset        = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        chk("rand_progress", 32'(n_pops > 300), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
